pipelined_adder_extending: RTL
==============================

// Module: pipelined_adder_extending
// PURPOSE
//  Elastic, pipelined N-bit adder producing an N+1-bit sum with carry-in.
//  The operands split into CHUNK_SIZE-bit slices, one per pipeline stage.
//  Carry ripples stage to stage through registers, so wide adds close timing.
//  Feeds wide neighbour-count and accumulator datapaths through a valid/ready handshake.
// PARAMETERS
//  INPUT_SIZE  8  operand width in bits (>=1)
//  CHUNK_SIZE  4  bits added per stage (1..INPUT_SIZE)
//  STAGES is derived, not overridable: ceil(INPUT_SIZE/CHUNK_SIZE); the last chunk may be narrower
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  in_valid   in   1             operands/c_in valid
//  in_ready   out  1             pipeline accepts operands this cycle
//  a          in   INPUT_SIZE    operand A, unsigned
//  b          in   INPUT_SIZE    operand B, unsigned
//  c_in       in   1             carry-in into bit 0
//  out_valid  out  1             sum valid
//  out_ready  in   1             consumer accepts sum this cycle
//  sum        out  INPUT_SIZE+1  a + b + c_in; MSB is final carry
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, data regs=0.
//    Hence out_valid=0, sum=0, in_ready=1.
//  - Transfers: input transfer = in_valid&&in_ready; output transfer = out_valid&&out_ready.
//  - Stage k (0..STAGES-1) adds chunk k of a/b with the registered carry of stage k-1.
//    Stage 0 uses c_in instead.
//    The stage registers its chunk sum, carry-out and the not-yet-consumed higher operand chunks.
//  - Latency: STAGES cycles from input transfer to out_valid=1 when unstalled.
//    Throughput is 1 result/cycle.
//  - Advance rule: stage k loads when stage k is empty or will be vacated this cycle.
//    A stage is vacated by stage k+1 loading from it, or, for the last stage, by an output transfer.
//    in_ready = stage 0 empty or stage 0 advancing; it is combinational from out_ready.
//  - Stall: with out_ready=0 the pipe fills; in_ready drops only once all STAGES hold data.
//    No data is lost or duplicated. A held result keeps sum stable while out_valid=1.
//  - Order: strict FIFO, with no reordering or bubbles inserted beyond those caused by in_valid=0.
//  - Simultaneous output and input transfer when full: allowed, and the pipe shifts as one.
//  - Width rules: sum[INPUT_SIZE] = carry out of the top bit.
//    Maximum is (2^N-1)+(2^N-1)+1 = 2^(N+1)-1, so there is never overflow.
//  - Edge case: CHUNK_SIZE=INPUT_SIZE gives STAGES=1, a registered adder with latency 1.
//  - Reset mid-operation: in-flight operations are dropped and out_valid falls asynchronously.
//    No result is emitted for them.
// CONFIGURATION
//  Macro PIPELINED_ADDER_OCCUPANCY_EN:
//  - Defined: adds output port occupancy [$clog2(STAGES+1)-1:0] = number of valid stages.
//    Reset value 0. It updates +1 on an input transfer only, -1 on an output transfer only,
//    and is unchanged when both or neither occur.
//  - Undefined: the port and its logic are absent; everything else is identical.
// STRUCTURE
//  - Package pipelined_adder_pkg:
//    - function num_stages(input_size, chunk_size) returning the ceil division
//    - function chunk_width(k, input_size, chunk_size) giving the last-chunk width
//  - Sub-module adder_pipe_stage, generated STAGES times:
//    - holds the valid flag, registered carry, chunk sum and the operand shift for one slice
//    - ports: in_valid/in_ready/out_valid/out_ready plus data; uses the same clk/reset
//  - Top: generate loop chaining the stages; concatenates the chunk sums and final carry into sum.
// TESTING (INPUT_SIZE=8, CHUNK_SIZE=4 unless stated)
//  1. Reset held: out_valid=0, sum=0, in_ready=1.
//     Assert reset mid-stream with 2 ops in flight -> out_valid=0 immediately; nothing is emitted after release.
//  2. a=0xFF, b=0x01, c_in=0, out_ready=1 -> sum=0x100 exactly 2 cycles after transfer.
//     a=0xFF, b=0xFF, c_in=1 -> 0x1FF. The carry crosses the chunk boundary.
//  3. Back-to-back: 16 ops (a=i, b=3i, c_in=i[0]) with in_valid and out_ready held high.
//     -> 16 consecutive results, in order, each equal to 4i+i[0], one per cycle.
//  4. Backpressure: out_ready=0 while pushing 3 ops.
//     -> in_ready drops after 2 accepted; sum/out_valid held stable.
//     Raise out_ready -> all 3 results emerge in order.
//  5. Random in_valid/out_ready at 50% over 10k ops, checked against a scoreboard model.
//     -> no loss, duplication or reordering. Repeat with CHUNK_SIZE=3 (STAGES=3, ragged top chunk) and CHUNK_SIZE=8.
//  6. PIPELINED_ADDER_OCCUPANCY_EN defined: fill to 2 with out_ready=0 -> occupancy=2.
//     A simultaneous push and pop holds it at 2; draining returns it to 0.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the chunked pipelined adder.
// Stage count and per-stage slice width derivation.
package pipelined_adder_pkg;

    function automatic int num_stages(input int input_size, input int chunk_size);
        return (input_size + chunk_size - 1) / chunk_size;
    endfunction

    // The top slice may be narrower when chunk_size does not divide input_size.
    function automatic int chunk_width(input int k, input int input_size,
                                       input int chunk_size);
        int rem;
        rem = input_size - k * chunk_size;
        return (rem < chunk_size) ? rem : chunk_size;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One slice of the pipelined adder: adds chunk K with the incoming carry
// and forwards operands, partial sum and carry behind a valid/ready register.
module adder_pipe_stage
    import pipelined_adder_pkg::*;
#(
    parameter int INPUT_SIZE = 8,
    parameter int CHUNK_SIZE = 4,
    parameter int K          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] a,
    input  logic [INPUT_SIZE-1:0] b,
    input  logic                  c_in,
    input  logic [INPUT_SIZE-1:0] psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE-1:0] a_q,
    output logic [INPUT_SIZE-1:0] b_q,
    output logic [INPUT_SIZE-1:0] psum_q,
    output logic                  c_out
);

    localparam int LO = K * CHUNK_SIZE;
    localparam int W  = chunk_width(K, INPUT_SIZE, CHUNK_SIZE);

    logic                  valid_q;
    logic [W:0]            add;
    logic [INPUT_SIZE-1:0] psum_nxt;

    always_comb begin
        add = {1'b0, a[LO+:W]} + {1'b0, b[LO+:W]} + {{W{1'b0}}, c_in};
        psum_nxt = psum;
        psum_nxt[LO+:W] = add[W-1:0];
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            c_out   <= 1'b0;
        end else begin
            if (in_ready)
                valid_q <= in_valid;
            if (in_valid && in_ready) begin
                a_q    <= a;
                b_q    <= b;
                psum_q <= psum_nxt;
                c_out  <= add[W];
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_extending.sv
// Elastic pipelined adder: sum = a + b + c_in, one CHUNK_SIZE slice per stage.
// Optional occupancy port under macro PIPELINED_ADDER_OCCUPANCY_EN.
module pipelined_adder_extending
    import pipelined_adder_pkg::*;
#(
    parameter int   INPUT_SIZE = 8,
    parameter int   CHUNK_SIZE = 4,
    localparam int  STAGES     = num_stages(INPUT_SIZE, CHUNK_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] a,
    input  logic [INPUT_SIZE-1:0] b,
    input  logic                  c_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE:0]   sum
`ifdef PIPELINED_ADDER_OCCUPANCY_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    for (genvar k = 0; k < STAGES; k++) begin : stg
        logic                  rdy;
        logic                  vld;
        logic                  cy;
        logic                  dn_rdy;
        logic                  up_vld;
        logic                  up_cy;
        logic [INPUT_SIZE-1:0] a_q;
        logic [INPUT_SIZE-1:0] b_q;
        logic [INPUT_SIZE-1:0] ps;
        logic [INPUT_SIZE-1:0] up_a;
        logic [INPUT_SIZE-1:0] up_b;
        logic [INPUT_SIZE-1:0] up_ps;

        if (k == 0) begin : g_first
            assign up_vld = in_valid;
            assign up_a   = a;
            assign up_b   = b;
            assign up_cy  = c_in;
            assign up_ps  = '0;
        end else begin : g_link
            assign up_vld = stg[k-1].vld;
            assign up_a   = stg[k-1].a_q;
            assign up_b   = stg[k-1].b_q;
            assign up_cy  = stg[k-1].cy;
            assign up_ps  = stg[k-1].ps;
        end

        // Last stage's forwarded operands have no consumer.
        if (k == STAGES - 1) begin : g_last
            logic unused_ops;
            assign dn_rdy     = out_ready;
            assign unused_ops = ^{a_q, b_q};
        end else begin : g_mid
            assign dn_rdy = stg[k+1].rdy;
        end

        adder_pipe_stage #(
            .INPUT_SIZE(INPUT_SIZE),
            .CHUNK_SIZE(CHUNK_SIZE),
            .K         (k)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .in_valid (up_vld),
            .in_ready (rdy),
            .a        (up_a),
            .b        (up_b),
            .c_in     (up_cy),
            .psum     (up_ps),
            .out_valid(vld),
            .out_ready(dn_rdy),
            .a_q      (a_q),
            .b_q      (b_q),
            .psum_q   (ps),
            .c_out    (cy)
        );
    end

    assign in_ready  = stg[0].rdy;
    assign out_valid = stg[STAGES-1].vld;
    assign sum       = {stg[STAGES-1].cy, stg[STAGES-1].ps};

`ifdef PIPELINED_ADDER_OCCUPANCY_EN
    localparam int OW = $clog2(STAGES + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            occupancy <= '0;
        else if (in_xfer && !out_xfer)
            occupancy <= occupancy + OW'(1);
        else if (out_xfer && !in_xfer)
            occupancy <= occupancy - OW'(1);
    end
`endif

endmodule
